logicnet_neuron_sched: RTL

//  Time-multiplexed evaluator for one LogicNet layer. NEURONS neurons share one runtime-loadable truth-table RAM.

---
 rtl/logicnet_pkg.sv | 26 ++
 rtl/logicnet_lut_ram.sv | 42 ++++
 rtl/logicnet_neuron_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/logicnet_pkg.sv
// ---------------------------------------------------------------------------
// logicnet_pkg
// Shared constants and types for the time-multiplexed LogicNet layer
// evaluator.
//   ACT_W        bits per activation (input features and neuron outputs)
//   FANIN        taps per neuron
//   LUT_AW       truth-table address width, one ACT_W field per tap
//   sched_state_e  scheduler FSM states
//   CFG_SEL_*    values of the config select input
// ---------------------------------------------------------------------------
package logicnet_pkg;

    localparam int ACT_W  = 2;
    localparam int FANIN  = 3;
    localparam int LUT_AW = FANIN * ACT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    localparam logic CFG_SEL_LUT = 1'b0;
    localparam logic CFG_SEL_TAP = 1'b1;

endpackage : logicnet_pkg

// File: rtl/logicnet_lut_ram.sv
// ---------------------------------------------------------------------------
// logicnet_lut_ram
// Truth-table storage shared by all neurons of the layer. One write port for
// runtime loading, one synchronous read port used by the scheduler. Contents
// are deliberately not reset so the array maps onto distributed RAM.
// Ports:
//   clk_i     clock
//   we_i      write enable
//   waddr_i   write address {neuron, entry}
//   wdata_i   truth-table output value
//   raddr_i   read address {neuron, entry}
//   rdata_o   registered read data, valid one cycle after raddr_i
// ---------------------------------------------------------------------------
module logicnet_lut_ram #(
    parameter int DEPTH = 512,
    parameter int DW    = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write and registered read share one clocked process; a read of the
    // address being written returns the old contents, which never matters
    // here because writes only happen while the scheduler is idle.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule : logicnet_lut_ram

// File: rtl/logicnet_neuron_sched.sv
// ---------------------------------------------------------------------------
// logicnet_neuron_sched
// Evaluates one LogicNet layer by walking its neurons one per cycle through a
// shared truth-table RAM. A sample is latched in IDLE, each neuron's tapped
// activations form a LUT address, and the registered RAM output is dropped
// into that neuron's output slot one cycle later. The finished vector is held
// in DONE until the downstream handshake.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   cfg_valid_i       config write request (accepted only in IDLE)
//   cfg_ready_o       high in IDLE
//   cfg_sel_i         0 = LUT entry write, 1 = tap index write
//   cfg_addr_i        LUT: {neuron, entry}; tap: neuron*FANIN + tap
//   cfg_data_i        LUT: output value in low ACT_W bits; tap: feature index
//   cfg_err_o         one-cycle pulse when a tap write was out of range
//   in_valid_i        sample valid
//   in_ready_o        sample accepted (IDLE and no config request)
//   in_data_i         feature f at [f*ACT_W +: ACT_W]
//   out_valid_o       layer result valid (DONE)
//   out_ready_i       downstream accepts result
//   out_data_o        neuron n at [n*ACT_W +: ACT_W]
// ---------------------------------------------------------------------------
module logicnet_neuron_sched
    import logicnet_pkg::*;
#(
    parameter int NEURONS = 8,
    parameter int IN_FEAT = 16,
    localparam int CFG_AW = $clog2(NEURONS << LUT_AW),
    localparam int CFG_DW = (ACT_W > $clog2(IN_FEAT)) ? ACT_W : $clog2(IN_FEAT)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic                       cfg_sel_i,
    input  logic [CFG_AW-1:0]          cfg_addr_i,
    input  logic [CFG_DW-1:0]          cfg_data_i,
    output logic                       cfg_err_o,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [IN_FEAT*ACT_W-1:0]   in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NEURONS*ACT_W-1:0]   out_data_o
);

    localparam int NW     = $clog2(NEURONS);
    localparam int FEAT_W = $clog2(IN_FEAT);
    localparam int TAPS   = NEURONS * FANIN;
    localparam int TAP_IW = $clog2(TAPS);

    sched_state_e      state_q, state_d;

    logic [NW:0]       nCnt_q;
    logic [NW-1:0]     nIdx;
    logic              wrPend_q;
    logic [NW-1:0]     wrIdx_q;
    logic              cfgErr_q;

    logic [ACT_W-1:0]  sample_q  [IN_FEAT];
    logic [ACT_W-1:0]  outSlot_q [NEURONS];
    logic [FEAT_W-1:0] tapIdx_q  [TAPS];

    logic              cfgFire;
    logic              inFire;
    logic              issue;
    logic              lastCapture;
    logic              tapOutOfRange;
    logic              tapWrite;
    logic              tapBad;
    logic              lutWrite;
    logic [31:0]       cfgAddrExt;
    logic [31:0]       cfgDataExt;

    logic [LUT_AW-1:0] lutAddr;
    logic [CFG_AW-1:0] ramRdAddr;
    logic [ACT_W-1:0]  ramRdData;

    // Handshake qualifiers. A config request in IDLE blocks the sample
    // handshake so config always wins a same-cycle collision.
    assign cfgFire     = (state_q == IDLE) && cfg_valid_i;
    assign inFire      = (state_q == IDLE) && !cfg_valid_i && in_valid_i;
    assign issue       = (state_q == EVAL) && (nCnt_q < (NW+1)'(NEURONS));
    assign lastCapture = wrPend_q && (wrIdx_q == NW'(NEURONS - 1));
    assign nIdx        = nCnt_q[NW-1:0];

    // Range checks are done at 32 bits so they stay meaningful for any
    // parameter set, including ones where the field can hold illegal values.
    assign cfgAddrExt    = 32'(cfg_addr_i);
    assign cfgDataExt    = 32'(cfg_data_i);
    assign tapOutOfRange = (cfgAddrExt >= 32'(TAPS)) || (cfgDataExt >= 32'(IN_FEAT));
    assign tapWrite      = cfgFire && (cfg_sel_i == CFG_SEL_TAP) && !tapOutOfRange;
    assign tapBad        = cfgFire && (cfg_sel_i == CFG_SEL_TAP) && tapOutOfRange;
    assign lutWrite      = cfgFire && (cfg_sel_i == CFG_SEL_LUT);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. EVAL ends once the last neuron's
    // RAM result has been captured, not when it is issued.
    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                in_ready_o  = !cfg_valid_i;
                if (inFire) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (lastCapture) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tap index register file. Reset to feature 0 so an unconfigured neuron
    // still produces a defined address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TAPS; i++) begin
                tapIdx_q[i] <= '0;
            end
        end else if (tapWrite) begin
            tapIdx_q[TAP_IW'(cfg_addr_i)] <= cfg_data_i[FEAT_W-1:0];
        end
    end

    // Tap mux: tap t of the neuron being issued selects a feature from the
    // latched sample and lands in address field t, tap 0 in the LSBs.
    always_comb begin
        lutAddr = '0;
        for (int t = 0; t < FANIN; t++) begin
            lutAddr[t*ACT_W +: ACT_W] =
                sample_q[tapIdx_q[TAP_IW'(32'(nIdx) * 32'(FANIN) + 32'(t))]];
        end
    end

    assign ramRdAddr = CFG_AW'({nIdx, lutAddr});

    logicnet_lut_ram #(
        .DEPTH (NEURONS << LUT_AW),
        .DW    (ACT_W)
    ) u_lut_ram (
        .clk_i   (clk_i),
        .we_i    (lutWrite),
        .waddr_i (cfg_addr_i),
        .wdata_i (cfg_data_i[ACT_W-1:0]),
        .raddr_i (ramRdAddr),
        .rdata_o (ramRdData)
    );

    // Datapath: sample capture, neuron counter, one-cycle write-back pipe
    // that tracks which slot the RAM output belongs to, and the error pulse.
    // Reset clears the output slots so an interrupted sample leaves nothing
    // behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nCnt_q   <= '0;
            wrPend_q <= 1'b0;
            wrIdx_q  <= '0;
            cfgErr_q <= 1'b0;
            for (int f = 0; f < IN_FEAT; f++) begin
                sample_q[f] <= '0;
            end
            for (int n = 0; n < NEURONS; n++) begin
                outSlot_q[n] <= '0;
            end
        end else begin
            cfgErr_q <= tapBad;
            if (inFire) begin
                for (int f = 0; f < IN_FEAT; f++) begin
                    sample_q[f] <= in_data_i[f*ACT_W +: ACT_W];
                end
                nCnt_q <= '0;
            end else if (issue) begin
                nCnt_q <= nCnt_q + 1'b1;
            end
            wrPend_q <= issue;
            wrIdx_q  <= nIdx;
            if (wrPend_q) begin
                outSlot_q[wrIdx_q] <= ramRdData;
            end
        end
    end

    // Flatten the output slots onto the result bus.
    always_comb begin
        out_data_o = '0;
        for (int n = 0; n < NEURONS; n++) begin
            out_data_o[n*ACT_W +: ACT_W] = outSlot_q[n];
        end
    end

    assign cfg_err_o = cfgErr_q;

endmodule : logicnet_neuron_sched
